// File: rtl/plane_offset_from_normal.sv
// Plane offset d = -(n . p0) for the RANSAC plane-fit path, built on one shared
// multi-cycle fused multiply-add that is reused for the x, y and z terms.

package ransac_fixed;
    localparam int unsigned value_width = 32;
    localparam int unsigned frac_bits   = 16;

    typedef logic signed [value_width-1:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vector3f_t;

    // bit 1 negates the product, bit 0 negates the addend
    typedef enum logic [1:0] {
        FMA_OPCODE_POS_A_POS_C = 2'b00,
        FMA_OPCODE_POS_A_NEG_C = 2'b01,
        FMA_OPCODE_NEG_A_POS_C = 2'b10,
        FMA_OPCODE_NEG_A_NEG_C = 2'b11
    } fma_opcode_t;

    function automatic int unsigned value_bits();
        return value_width;
    endfunction
endpackage

// Non-pipelined Q16.16 fused multiply-add: one rounding, saturating, fixed latency.
module slow_fp_fused_multiply_add
    import ransac_fixed::*;
#(
    parameter int unsigned latency = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        input_valid,
    output logic        input_ready,
    input  fixed_t      a,
    input  fixed_t      b,
    input  fixed_t      c,
    input  fma_opcode_t opcode,
    output logic        output_valid,
    output fixed_t      result
);
    localparam int unsigned eff_latency = (latency < 1) ? 1 : latency;
    localparam int unsigned count_width = 8;
    localparam logic signed [63:0] sat_max = 64'sh0000_0000_7fff_ffff;
    localparam logic signed [63:0] sat_min = 64'shffff_ffff_8000_0000;
    localparam logic signed [63:0] half_lsb = 64'sd32768;

    logic signed [63:0] a_ext, b_ext, c_ext, prod, sum, rounded;
    fixed_t             sat_value;
    logic               busy_q;
    logic [count_width-1:0] count_q;

    // Exact product plus aligned addend, rounded half-up once, then clamped.
    always_comb begin
        a_ext   = {{32{a[31]}}, a};
        b_ext   = {{32{b[31]}}, b};
        c_ext   = {{16{c[31]}}, c, 16'h0000};
        prod    = a_ext * b_ext;
        sum     = (opcode[1] ? -prod : prod) + (opcode[0] ? -c_ext : c_ext);
        rounded = (sum + half_lsb) >>> frac_bits;
        if (rounded > sat_max) begin
            sat_value = fixed_t'(sat_max[31:0]);
        end else if (rounded < sat_min) begin
            sat_value = fixed_t'(sat_min[31:0]);
        end else begin
            sat_value = fixed_t'(rounded[31:0]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q       <= 1'b0;
            count_q      <= '0;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
            result       <= '0;
        end else begin
            output_valid <= 1'b0;
            if (!busy_q) begin
                if (input_valid && input_ready) begin
                    busy_q      <= 1'b1;
                    input_ready <= 1'b0;
                    count_q     <= count_width'(eff_latency - 1);
                    result      <= sat_value;
                end
            end else if (count_q == '0) begin
                busy_q       <= 1'b0;
                input_ready  <= 1'b1;
                output_valid <= 1'b1;
            end else begin
                count_q <= count_q - count_width'(1);
            end
        end
    end
endmodule

module plane_offset_from_normal
    import ransac_fixed::*;
#(
    parameter int unsigned multiply_latency = ransac_fixed::value_bits() / 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      input_valid,
    input  vector3f_t normal,
    input  vector3f_t point,
    output logic      input_ready,
    output logic      output_valid,
    input  logic      output_ready,
    output vector3f_t plane_normal,
    output fixed_t    plane_offset,
    output logic      degenerate
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t    state_q, state_d;
    vector3f_t n_q, n_d, p_q, p_d;
    logic [1:0] k_q, k_d;
    fixed_t    acc_q, acc_d;
    logic      fma_valid, fma_valid_d;
    logic      input_ready_d, output_valid_d, degenerate_d;
    vector3f_t plane_normal_d;
    fixed_t    plane_offset_d;

    logic      fma_ready, fma_out_valid;
    fixed_t    fma_a, fma_b, fma_c, fma_result;

    function automatic fixed_t component(input vector3f_t v, input logic [1:0] k);
        case (k)
            2'd0:    return v.x;
            2'd1:    return v.y;
            default: return v.z;
        endcase
    endfunction

    // Term k contributes -n[k]*p[k] on top of the running sum.
    always_comb begin
        fma_a = component(n_q, k_q);
        fma_b = component(p_q, k_q);
        fma_c = (k_q == 2'd0) ? fixed_t'(0) : acc_q;
    end

    slow_fp_fused_multiply_add #(
        .latency(multiply_latency)
    ) u_fma (
        .clock       (clock),
        .reset       (reset),
        .input_valid (fma_valid),
        .input_ready (fma_ready),
        .a           (fma_a),
        .b           (fma_b),
        .c           (fma_c),
        .opcode      (FMA_OPCODE_NEG_A_POS_C),
        .output_valid(fma_out_valid),
        .result      (fma_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            p_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            fma_valid    <= 1'b0;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
            plane_normal <= '0;
            plane_offset <= '0;
            degenerate   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            p_q          <= p_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            fma_valid    <= fma_valid_d;
            input_ready  <= input_ready_d;
            output_valid <= output_valid_d;
            plane_normal <= plane_normal_d;
            plane_offset <= plane_offset_d;
            degenerate   <= degenerate_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        p_d            = p_q;
        k_d            = k_q;
        acc_d          = acc_q;
        fma_valid_d    = fma_valid;
        input_ready_d  = input_ready;
        output_valid_d = output_valid;
        plane_normal_d = plane_normal;
        plane_offset_d = plane_offset;
        degenerate_d   = degenerate;

        case (state_q)
            IDLE: begin
                if (input_valid && input_ready) begin
                    n_d           = normal;
                    p_d           = point;
                    k_d           = '0;
                    acc_d         = '0;
                    input_ready_d = 1'b0;
                    // A zero normal means collinear samples: report it without using the FMA.
                    if (normal == '0) begin
                        state_d        = DONE;
                        plane_normal_d = '0;
                        plane_offset_d = '0;
                        degenerate_d   = 1'b1;
                        output_valid_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        fma_valid_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (fma_ready) begin
                    fma_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (fma_out_valid) begin
                    acc_d = fma_result;
                    if (k_q == 2'd2) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d         = k_q + 2'd1;
                        fma_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            DONE: begin
                if (!output_valid) begin
                    plane_normal_d = n_q;
                    plane_offset_d = acc_q;
                    degenerate_d   = 1'b0;
                    output_valid_d = 1'b1;
                end else if (output_ready) begin
                    output_valid_d = 1'b0;
                    input_ready_d  = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_plane_offset_from_normal.sv
// Self-checking bench for plane_offset_from_normal against a Q16.16 arithmetic model.
module tb_plane_offset_from_normal;
    import ransac_fixed::*;

    localparam int unsigned lat_fma = ransac_fixed::value_bits() / 8;
    localparam int lat_full = 1 + 3 * (2 + int'(lat_fma)) + 1;

    logic      clock = 1'b0;
    logic      reset = 1'b1;
    logic      input_valid = 1'b0;
    vector3f_t normal = '0;
    vector3f_t point = '0;
    logic      input_ready;
    logic      output_valid;
    logic      output_ready = 1'b0;
    vector3f_t plane_normal;
    fixed_t    plane_offset;
    logic      degenerate;

    int n_checks = 0;
    int n_fail = 0;
    int fma_issues = 0;

    plane_offset_from_normal dut (
        .clock       (clock),
        .reset       (reset),
        .input_valid (input_valid),
        .normal      (normal),
        .point       (point),
        .input_ready (input_ready),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .plane_normal(plane_normal),
        .plane_offset(plane_offset),
        .degenerate  (degenerate)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dut.fma_valid && dut.fma_ready) fma_issues++;
    end

    function automatic fixed_t fx(input real r);
        return fixed_t'($rtoi(r * 65536.0));
    endfunction

    function automatic vector3f_t v3(input real x, input real y, input real z);
        vector3f_t v;
        v.x = fx(x);
        v.y = fx(y);
        v.z = fx(z);
        return v;
    endfunction

    // r = -a*b + c in exact integer arithmetic, one half-up rounding, clamped to 32 bits.
    function automatic fixed_t model_fma(input fixed_t a, input fixed_t b, input fixed_t c);
        longint s;
        s = -(longint'(a) * longint'(b)) + longint'(c) * 64'sd65536;
        s = (s + 64'sd32768) >>> 16;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return fixed_t'(s[31:0]);
    endfunction

    function automatic fixed_t model_offset(input vector3f_t n, input vector3f_t p);
        fixed_t acc;
        if (n == '0) return '0;
        acc = model_fma(n.x, p.x, 32'sd0);
        acc = model_fma(n.y, p.y, acc);
        acc = model_fma(n.z, p.z, acc);
        return acc;
    endfunction

    task automatic run_job(input vector3f_t n, input vector3f_t p, input int ready_delay,
                           output fixed_t off, output vector3f_t nrm, output logic deg,
                           output int lat, output int issues, output bit ok);
        int wait_cnt;
        int start_issues;
        wait_cnt = 0;
        @(negedge clock);
        normal = n;
        point = p;
        input_valid = 1'b1;
        output_ready = 1'b0;
        while (!input_ready && wait_cnt < 200) begin
            @(negedge clock);
            wait_cnt++;
        end
        start_issues = fma_issues;
        @(negedge clock);
        input_valid = 1'b0;
        lat = 1;
        while (!output_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        ok = output_valid && (wait_cnt < 200);
        off = plane_offset;
        nrm = plane_normal;
        deg = degenerate;
        issues = fma_issues - start_issues;
        repeat (ready_delay) @(negedge clock);
        output_ready = 1'b1;
        @(negedge clock);
        output_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL reset_input_ready got=%b want=1", input_ready); end
        n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_output_valid got=%b want=0", output_valid); end
        n_checks++; if (plane_normal !== '0) begin n_fail++; $display("FAIL reset_plane_normal got=%h want=0", plane_normal); end
        n_checks++; if (plane_offset !== '0) begin n_fail++; $display("FAIL reset_plane_offset got=%h want=0", plane_offset); end
        n_checks++; if (degenerate !== 1'b0) begin n_fail++; $display("FAIL reset_degenerate got=%b want=0", degenerate); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        fixed_t off; vector3f_t nrm; logic deg; int lat, issues; bit ok;
        run_job(v3(1, 2, 3), v3(4, 5, 6), 0, off, nrm, deg, lat, issues, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got=no_output want=output"); end
        n_checks++; if (off !== fx(-32)) begin n_fail++; $display("FAIL basic_offset got=%h want=%h", off, fx(-32)); end
        n_checks++; if (nrm !== v3(1, 2, 3)) begin n_fail++; $display("FAIL basic_normal got=%h want=%h", nrm, v3(1, 2, 3)); end
        n_checks++; if (deg !== 1'b0) begin n_fail++; $display("FAIL basic_degenerate got=%b want=0", deg); end
        n_checks++; if (issues != 3) begin n_fail++; $display("FAIL basic_fma_issues got=%0d want=3", issues); end
        n_checks++; if (lat != lat_full) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, lat_full); end
        repeat (3) @(negedge clock);
        n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse got=%b want=0", output_valid); end
    endtask

    task automatic test_exact();
        fixed_t off; vector3f_t nrm; logic deg; int lat, issues; bit ok;
        run_job(v3(0, 0, 1), v3(7, -3, 2), 0, off, nrm, deg, lat, issues, ok);
        n_checks++; if (!ok || off !== fx(-2)) begin n_fail++; $display("FAIL exact_z_offset got=%h want=%h", off, fx(-2)); end
        run_job(v3(-1.5, 0, 0.5), v3(2, 4, -2), 1, off, nrm, deg, lat, issues, ok);
        n_checks++; if (!ok || off !== fx(4.0)) begin n_fail++; $display("FAIL exact_frac_offset got=%h want=%h", off, fx(4.0)); end
        n_checks++; if (off !== model_offset(v3(-1.5, 0, 0.5), v3(2, 4, -2))) begin
            n_fail++; $display("FAIL exact_frac_model got=%h want=%h", off, model_offset(v3(-1.5, 0, 0.5), v3(2, 4, -2)));
        end
    endtask

    task automatic test_degenerate();
        fixed_t off; vector3f_t nrm; logic deg; int lat, issues; bit ok;
        run_job(v3(0, 0, 0), v3(9, 9, 9), 0, off, nrm, deg, lat, issues, ok);
        n_checks++; if (!ok || deg !== 1'b1) begin n_fail++; $display("FAIL degen_flag got=%b want=1", deg); end
        n_checks++; if (off !== '0) begin n_fail++; $display("FAIL degen_offset got=%h want=0", off); end
        n_checks++; if (nrm !== '0) begin n_fail++; $display("FAIL degen_normal got=%h want=0", nrm); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL degen_latency got=%0d want=1", lat); end
        n_checks++; if (issues != 0) begin n_fail++; $display("FAIL degen_fma_issues got=%0d want=0", issues); end
    endtask

    task automatic test_backpressure();
        int cnt;
        fixed_t snap_off;
        vector3f_t snap_n;
        cnt = 0;
        @(negedge clock);
        normal = v3(2, 0, 0);
        point = v3(3, 0, 0);
        input_valid = 1'b1;
        output_ready = 1'b0;
        while (!input_ready && cnt < 200) begin @(negedge clock); cnt++; end
        @(negedge clock);
        input_valid = 1'b0;
        while (!output_valid && cnt < 400) begin @(negedge clock); cnt++; end
        n_checks++; if (!output_valid) begin n_fail++; $display("FAIL bp_timeout got=no_output want=output"); end
        snap_off = plane_offset;
        snap_n = plane_normal;
        n_checks++; if (snap_off !== fx(-6)) begin n_fail++; $display("FAIL bp_offset got=%h want=%h", snap_off, fx(-6)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (output_valid !== 1'b1 || plane_offset !== snap_off || plane_normal !== v3(2, 0, 0) || input_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d got v=%b off=%h n=%h rdy=%b want v=1 off=%h n=%h rdy=0",
                         i, output_valid, plane_offset, plane_normal, input_ready, snap_off, v3(2, 0, 0));
            end
        end
        output_ready = 1'b1;
        @(negedge clock);
        output_ready = 1'b0;
        n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b want=0", output_valid); end
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b want=1", input_ready); end
    endtask

    task automatic test_reset_mid();
        fixed_t off; vector3f_t nrm; logic deg; int lat, issues; bit ok;
        int cnt;
        cnt = 0;
        @(negedge clock);
        normal = v3(1, 2, 3);
        point = v3(4, 5, 6);
        input_valid = 1'b1;
        while (!input_ready && cnt < 200) begin @(negedge clock); cnt++; end
        @(negedge clock);
        input_valid = 1'b0;
        repeat (2 + 2 + int'(lat_fma)) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0 || plane_normal !== '0 || plane_offset !== '0 || degenerate !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got rdy=%b v=%b n=%h off=%h deg=%b want rdy=1 v=0 n=0 off=0 deg=0",
                     input_ready, output_valid, plane_normal, plane_offset, degenerate);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_job(v3(1, 1, 1), v3(1, 1, 1), 0, off, nrm, deg, lat, issues, ok);
        n_checks++; if (!ok || off !== fx(-3)) begin n_fail++; $display("FAIL midreset_next_offset got=%h want=%h", off, fx(-3)); end
        n_checks++; if (issues != 3) begin n_fail++; $display("FAIL midreset_fma_issues got=%0d want=3", issues); end
    endtask

    task automatic test_back_to_back();
        vector3f_t in_n[2];
        vector3f_t in_p[2];
        fixed_t results[$];
        int idx, cyc;
        bit accept_now;
        in_n[0] = v3(1, 2, 3); in_p[0] = v3(4, 5, 6);
        in_n[1] = v3(0, 1, 0); in_p[1] = v3(0, 5, 0);
        idx = 0;
        cyc = 0;
        @(negedge clock);
        output_ready = 1'b1;
        normal = in_n[0];
        point = in_p[0];
        input_valid = 1'b1;
        while (results.size() < 2 && cyc < 300) begin
            accept_now = input_ready && input_valid;
            if (output_valid && output_ready) results.push_back(plane_offset);
            @(negedge clock);
            cyc++;
            if (accept_now) begin
                idx++;
                if (idx < 2) begin
                    normal = in_n[idx];
                    point = in_p[idx];
                end else begin
                    input_valid = 1'b0;
                end
            end
        end
        input_valid = 1'b0;
        output_ready = 1'b0;
        n_checks++; if (results.size() != 2) begin n_fail++; $display("FAIL b2b_count got=%0d want=2", results.size()); end
        n_checks++; if (idx != 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d want=2", idx); end
        if (results.size() == 2) begin
            n_checks++; if (results[0] !== fx(-32)) begin n_fail++; $display("FAIL b2b_first got=%h want=%h", results[0], fx(-32)); end
            n_checks++; if (results[1] !== fx(-5)) begin n_fail++; $display("FAIL b2b_second got=%h want=%h", results[1], fx(-5)); end
        end
    endtask

    task automatic test_random();
        fixed_t off; vector3f_t nrm; logic deg; int lat, issues; bit ok;
        vector3f_t n, p;
        for (int j = 0; j < 16; j++) begin
            n.x = fixed_t'(int'($urandom_range(0, 2097152)) - 1048576);
            n.y = fixed_t'(int'($urandom_range(0, 2097152)) - 1048576);
            n.z = fixed_t'(int'($urandom_range(0, 2097152)) - 1048576);
            p.x = fixed_t'(int'($urandom_range(0, 2097152)) - 1048576);
            p.y = fixed_t'(int'($urandom_range(0, 2097152)) - 1048576);
            p.z = fixed_t'(int'($urandom_range(0, 2097152)) - 1048576);
            if ($urandom_range(0, 5) == 0) n = '0;
            run_job(n, p, int'($urandom_range(0, 3)), off, nrm, deg, lat, issues, ok);
            n_checks++;
            if (!ok || off !== model_offset(n, p) || nrm !== n || deg !== (n == '0)) begin
                n_fail++;
                $display("FAIL random_job%0d got off=%h n=%h deg=%b want off=%h n=%h deg=%b",
                         j, off, nrm, deg, model_offset(n, p), n, (n == '0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exact();
        test_degenerate();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
